// File: rtl/buck_boost_pkg.sv
// Shared fixed-point defaults and arithmetic helpers for the buck-boost HIL loop.
package buck_boost_pkg;

    localparam int DEF_DATA_WIDTH         = 32;
    localparam int DEF_DATA_WIDTH_DECIMAL = 20;

    // Helpers work on a wide container; callers sign-extend in and truncate out.
    localparam int QW = 64;

    function automatic logic signed [QW-1:0] mul_q(
        input logic signed [QW-1:0] a,
        input logic signed [QW-1:0] b,
        input int                   frac
    );
        logic signed [2*QW-1:0] prod;
        prod = (2*QW)'(a) * (2*QW)'(b);
        return QW'(prod >>> frac);
    endfunction

    // Lower bound applied last so that lo > hi always yields lo.
    function automatic logic signed [QW-1:0] clamp_q(
        input logic signed [QW-1:0] x,
        input logic signed [QW-1:0] lo,
        input logic signed [QW-1:0] hi
    );
        logic signed [QW-1:0] y;
        y = (x > hi) ? hi : x;
        return (y < lo) ? lo : y;
    endfunction

endpackage

// File: rtl/model_buck_boost_l1.sv
// Forward-Euler inverting buck-boost plant with ideal diode and discontinuous conduction.
module model_buck_boost_l1
    import buck_boost_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_DECIMAL = DEF_DATA_WIDTH_DECIMAL
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         s1,
    input  logic signed [DATA_WIDTH-1:0] kL,
    input  logic signed [DATA_WIDTH-1:0] kC,
    input  logic signed [DATA_WIDTH-1:0] kR,
    input  logic signed [DATA_WIDTH-1:0] vdc,
    output logic signed [DATA_WIDTH-1:0] iL,
    output logic signed [DATA_WIDTH-1:0] vL,
    output logic signed [DATA_WIDTH-1:0] iC,
    output logic signed [DATA_WIDTH-1:0] iO,
    output logic signed [DATA_WIDTH-1:0] vO
);

    logic signed [DATA_WIDTH-1:0] io_next;
    logic signed [DATA_WIDTH-1:0] vl_next;
    logic signed [DATA_WIDTH-1:0] ic_next;
    logic signed [DATA_WIDTH-1:0] il_sum;
    logic signed [DATA_WIDTH-1:0] il_next;
    logic signed [DATA_WIDTH-1:0] vo_next;
    logic                         il_pos;

    always_comb begin
        il_pos  = !iL[DATA_WIDTH-1] && (iL != '0);
        io_next = DATA_WIDTH'(mul_q(QW'(vO), QW'(kR), DATA_WIDTH_DECIMAL));
        vl_next = '0;
        ic_next = -io_next;
        if (s1) begin
            vl_next = vdc;
        end else if (il_pos) begin
            vl_next = vO;
            ic_next = -iL - io_next;
        end
        il_sum  = iL + DATA_WIDTH'(mul_q(QW'(vl_next), QW'(kL), DATA_WIDTH_DECIMAL));
        // The diode blocks reverse inductor current while the switch is open.
        il_next = (!s1 && il_sum[DATA_WIDTH-1]) ? '0 : il_sum;
        vo_next = vO + DATA_WIDTH'(mul_q(QW'(ic_next), QW'(kC), DATA_WIDTH_DECIMAL));
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            iL <= '0;
            vL <= '0;
            iC <= '0;
            iO <= '0;
            vO <= '0;
        end else if (ce) begin
            iL <= il_next;
            vL <= vl_next;
            iC <= ic_next;
            iO <= io_next;
            vO <= vo_next;
        end
    end

endmodule

// File: rtl/pi_l1.sv
// PI voltage regulator acting on output-voltage magnitude, with clamped integrator.
module pi_l1
    import buck_boost_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_DECIMAL = DEF_DATA_WIDTH_DECIMAL
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic signed [DATA_WIDTH-1:0] vo,
    input  logic signed [DATA_WIDTH-1:0] reference,
    input  logic signed [DATA_WIDTH-1:0] kp,
    input  logic signed [DATA_WIDTH-1:0] ki,
    input  logic signed [DATA_WIDTH-1:0] max,
    input  logic signed [DATA_WIDTH-1:0] min,
    output logic signed [DATA_WIDTH-1:0] duty_q
);

    logic signed [DATA_WIDTH-1:0] integ;
    logic signed [DATA_WIDTH-1:0] meas;
    logic signed [DATA_WIDTH-1:0] err;
    logic signed [DATA_WIDTH-1:0] integ_sum;
    logic signed [DATA_WIDTH-1:0] integ_next;
    logic signed [DATA_WIDTH-1:0] prop_sum;
    logic signed [DATA_WIDTH-1:0] duty_next;

    // Intermediate sums are held at DATA_WIDTH so they wrap before clamping.
    always_comb begin
        meas       = -vo;
        err        = reference - meas;
        integ_sum  = integ + DATA_WIDTH'(mul_q(QW'(err), QW'(ki), DATA_WIDTH_DECIMAL));
        integ_next = DATA_WIDTH'(clamp_q(QW'(integ_sum), QW'(min), QW'(max)));
        prop_sum   = DATA_WIDTH'(mul_q(QW'(err), QW'(kp), DATA_WIDTH_DECIMAL)) + integ_next;
        duty_next  = DATA_WIDTH'(clamp_q(QW'(prop_sum), QW'(min), QW'(max)));
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            integ  <= '0;
            duty_q <= '0;
        end else if (ce) begin
            integ  <= integ_next;
            duty_q <= duty_next;
        end
    end

endmodule

// File: rtl/pwm_l1.sv
// Counter-based PWM modulator; the counter advances and the output updates on ce only.
module pwm_l1 (
    input  logic        aclk,
    input  logic        reset,
    input  logic        ce,
    input  logic [31:0] period,
    input  logic [31:0] cmp,
    output logic        pwm
);

    logic [31:0] cnt;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else if (ce) begin
            if (period == 32'd0) begin
                cnt <= '0;
                pwm <= 1'b0;
            end else begin
                cnt <= (cnt >= period - 32'd1) ? 32'd0 : cnt + 32'd1;
                pwm <= (cnt < cmp);
            end
        end
    end

endmodule

// File: rtl/buck_boost_loop_l1.sv
// Closed-loop buck-boost HIL model: PI regulator, PWM modulator and converter plant.
module buck_boost_loop_l1
    import buck_boost_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_DECIMAL = DEF_DATA_WIDTH_DECIMAL
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         ce_model,
    input  logic                         ce_ctrl,
    input  logic signed [DATA_WIDTH-1:0] kL,
    input  logic signed [DATA_WIDTH-1:0] kC,
    input  logic signed [DATA_WIDTH-1:0] kR,
    input  logic signed [DATA_WIDTH-1:0] vdc,
    input  logic signed [DATA_WIDTH-1:0] reference,
    input  logic signed [DATA_WIDTH-1:0] kp,
    input  logic signed [DATA_WIDTH-1:0] ki,
    input  logic signed [DATA_WIDTH-1:0] max,
    input  logic signed [DATA_WIDTH-1:0] min,
    input  logic [31:0]                  period,
    output logic                         pwm,
    output logic signed [DATA_WIDTH-1:0] duty_q,
    output logic signed [DATA_WIDTH-1:0] iL,
    output logic signed [DATA_WIDTH-1:0] vL,
    output logic signed [DATA_WIDTH-1:0] iC,
    output logic signed [DATA_WIDTH-1:0] iO,
    output logic signed [DATA_WIDTH-1:0] vO
);

    logic [31:0] cmp;

    // Integer part of the duty command; a negative command never switches.
    assign cmp = duty_q[DATA_WIDTH-1] ? 32'd0 : 32'(duty_q[DATA_WIDTH-1:DATA_WIDTH_DECIMAL]);

    pi_l1 #(
        .DATA_WIDTH         (DATA_WIDTH),
        .DATA_WIDTH_DECIMAL (DATA_WIDTH_DECIMAL)
    ) u_pi (
        .aclk      (aclk),
        .reset     (reset),
        .ce        (ce_ctrl),
        .vo        (vO),
        .reference (reference),
        .kp        (kp),
        .ki        (ki),
        .max       (max),
        .min       (min),
        .duty_q    (duty_q)
    );

    pwm_l1 u_pwm (
        .aclk   (aclk),
        .reset  (reset),
        .ce     (ce_ctrl),
        .period (period),
        .cmp    (cmp),
        .pwm    (pwm)
    );

    model_buck_boost_l1 #(
        .DATA_WIDTH         (DATA_WIDTH),
        .DATA_WIDTH_DECIMAL (DATA_WIDTH_DECIMAL)
    ) u_plant (
        .aclk  (aclk),
        .reset (reset),
        .ce    (ce_model),
        .s1    (pwm),
        .kL    (kL),
        .kC    (kC),
        .kR    (kR),
        .vdc   (vdc),
        .iL    (iL),
        .vL    (vL),
        .iC    (iC),
        .iO    (iO),
        .vO    (vO)
    );

endmodule

// File: tb/tb_buck_boost_loop_l1.sv
// Self-checking bench for buck_boost_loop_l1: vector table, directed sequences, random closed loop vs model.
module tb_buck_boost_loop_l1;

    localparam int F   = 20;
    localparam int ONE = 1 << F;

    logic               aclk = 1'b0;
    logic               reset;
    logic               ce_model, ce_ctrl;
    logic signed [31:0] kL, kC, kR, vdc, reference, kp, ki, max_v, min_v;
    logic [31:0]        period;
    logic               pwm;
    logic signed [31:0] duty_q, iL, vL, iC, iO, vO;

    always #5 aclk = ~aclk;

    buck_boost_loop_l1 dut (
        .aclk(aclk), .reset(reset), .ce_model(ce_model), .ce_ctrl(ce_ctrl),
        .kL(kL), .kC(kC), .kR(kR), .vdc(vdc), .reference(reference),
        .kp(kp), .ki(ki), .max(max_v), .min(min_v), .period(period),
        .pwm(pwm), .duty_q(duty_q), .iL(iL), .vL(vL), .iC(iC), .iO(iO), .vO(vO)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, advanced once per active clock edge.
    int    m_iL, m_vO, m_vL, m_iC, m_iO, m_integ, m_duty;
    longint m_cnt;
    bit    m_pwm;

    function automatic int mq(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> F);
    endfunction

    function automatic int lim(int x, int lo, int hi);
        if (lo > hi) return lo;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_iL = 0; m_vO = 0; m_vL = 0; m_iC = 0; m_iO = 0;
        m_integ = 0; m_duty = 0; m_cnt = 0; m_pwm = 0;
    endtask

    task automatic model_edge(input bit cm, input bit cc);
        int n_iL, n_vO, n_vL, n_iC, n_iO, n_integ, n_duty, e;
        longint n_cnt, cmp;
        bit n_pwm;
        n_iL = m_iL; n_vO = m_vO; n_vL = m_vL; n_iC = m_iC; n_iO = m_iO;
        n_integ = m_integ; n_duty = m_duty; n_cnt = m_cnt; n_pwm = m_pwm;
        if (cm) begin
            n_iO = mq(m_vO, kR);
            if (m_pwm) begin
                n_vL = vdc; n_iC = -n_iO;
            end else if (m_iL > 0) begin
                n_vL = m_vO; n_iC = -m_iL - n_iO;
            end else begin
                n_vL = 0; n_iC = -n_iO;
            end
            n_iL = m_iL + mq(n_vL, kL);
            if (!m_pwm && n_iL < 0) n_iL = 0;
            n_vO = m_vO + mq(n_iC, kC);
        end
        if (cc) begin
            e = reference - (-m_vO);
            n_integ = lim(m_integ + mq(e, ki), min_v, max_v);
            n_duty  = lim(mq(e, kp) + n_integ, min_v, max_v);
            cmp = (m_duty < 0) ? 0 : longint'(m_duty >>> F);
            if (period == 0) begin
                n_cnt = 0; n_pwm = 0;
            end else begin
                n_pwm = (m_cnt < cmp);
                n_cnt = (m_cnt + 1 >= longint'(period)) ? 0 : m_cnt + 1;
            end
        end
        m_iL = n_iL; m_vO = n_vO; m_vL = n_vL; m_iC = n_iC; m_iO = n_iO;
        m_integ = n_integ; m_duty = n_duty; m_cnt = n_cnt; m_pwm = n_pwm;
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.iL", tag), iL, m_iL);
        check($sformatf("%s.vO", tag), vO, m_vO);
        check($sformatf("%s.vL", tag), vL, m_vL);
        check($sformatf("%s.iC", tag), iC, m_iC);
        check($sformatf("%s.iO", tag), iO, m_iO);
        check($sformatf("%s.duty", tag), duty_q, m_duty);
        check($sformatf("%s.pwm", tag), longint'(pwm), longint'(m_pwm));
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s.iL", tag), iL, 0);
        check($sformatf("%s.vO", tag), vO, 0);
        check($sformatf("%s.vL", tag), vL, 0);
        check($sformatf("%s.iC", tag), iC, 0);
        check($sformatf("%s.iO", tag), iO, 0);
        check($sformatf("%s.duty", tag), duty_q, 0);
        check($sformatf("%s.pwm", tag), longint'(pwm), 0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic tick(input bit cm, input bit cc);
        ce_model = cm;
        ce_ctrl  = cc;
        @(posedge aclk);
        model_edge(cm, cc);
        @(negedge aclk);
        ce_model = 1'b0;
        ce_ctrl  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        string name;
        int    ref_v, kp_v, ki_v, mx, mn, exp_duty;
    } pi_vec_t;

    pi_vec_t vecs[6];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs, min_il, steps;
        bit reached;
        reset = 1'b1; ce_model = 1'b0; ce_ctrl = 1'b0;
        kL = 10486; kC = 3177; kR = 209715; vdc = 104857600;
        reference = 0; kp = 0; ki = 0; max_v = 90 * ONE; min_v = 0; period = 100;
        model_reset();

        // Reset held, then released with no strobes.
        repeat (4) @(negedge aclk);
        check_zero("reset");
        reset = 1'b0;
        repeat (3) tick(0, 0);
        check_zero("idle");

        // One PI update from a cleared state with the plant at vO = 0.
        vecs[0] = '{"pi_basic",   10 * ONE,  ONE,     ONE / 2, 90 * ONE,  0,          15 * ONE};
        vecs[1] = '{"pi_sat_hi", 100 * ONE,  ONE,     0,       90 * ONE,  0,          90 * ONE};
        vecs[2] = '{"pi_sat_lo", -10 * ONE,  ONE,     0,       90 * ONE,  0,          0};
        vecs[3] = '{"pi_min_gt", 10 * ONE,   ONE,     0,       5 * ONE,   20 * ONE,   20 * ONE};
        vecs[4] = '{"pi_frac",   7 * ONE / 2, 2 * ONE, ONE,    90 * ONE,  -50 * ONE,  21 * ONE / 2};
        vecs[5] = '{"pi_neg",    -20 * ONE,  ONE,     ONE,     90 * ONE,  -50 * ONE,  -40 * ONE};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            reference = vecs[i].ref_v; kp = vecs[i].kp_v; ki = vecs[i].ki_v;
            max_v = vecs[i].mx; min_v = vecs[i].mn;
            tick(0, 1);
            check(vecs[i].name, duty_q, vecs[i].exp_duty);
        end

        // PWM alone: duty fixed by pinning both PI limits.
        apply_reset();
        reference = 0; kp = 0; ki = 0; period = 100;
        max_v = 30 * ONE; min_v = 30 * ONE;
        tick(0, 1);
        check("pwm_duty30", duty_q, 30 * ONE);
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            tick(0, 1);
            if (pwm) highs++;
        end
        check("pwm_30_of_100", highs, 60);
        max_v = 95 * ONE; min_v = 95 * ONE;
        tick(0, 1);
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            tick(0, 1);
            if (pwm) highs++;
        end
        check("pwm_95_of_100", highs, 190);
        check_model("pwm95");
        period = 0;
        tick(0, 1);
        check("pwm_period0_a", longint'(pwm), 0);
        tick(0, 1);
        check("pwm_period0_b", longint'(pwm), 0);
        period = 100; max_v = 200 * ONE; min_v = 200 * ONE;
        tick(0, 1);
        highs = 0;
        for (int i = 0; i < 150; i++) begin
            tick(0, 1);
            if (pwm) highs++;
        end
        check("pwm_cmp_ge_period", highs, 150);

        // Plant with switch held on, then released into decay.
        apply_reset();
        tick(0, 1);
        tick(0, 1);
        check("plant_s1_on", longint'(pwm), 1);
        tick(1, 0);
        check("plant_first_iL", iL, 1048600);
        check("plant_first_vO", vO, 0);
        check("plant_first_vL", vL, 104857600);
        repeat (4) tick(1, 0);
        check("plant_5_iL", iL, 5 * 1048600);
        max_v = 0; min_v = 0;
        tick(0, 1);
        tick(0, 1);
        check("plant_s1_off", longint'(pwm), 0);
        min_il = iL; reached = 0; steps = 0;
        while (!reached && steps < 2000) begin
            tick(1, 0);
            steps++;
            if (iL < min_il) min_il = iL;
            if (iL == 0) reached = 1;
        end
        check("plant_iL_reaches_0", longint'(reached), 1);
        check("plant_vO_negative", longint'(vO < 0), 1);
        repeat (5) begin
            tick(1, 0);
            if (iL < min_il) min_il = iL;
        end
        check("plant_iL_never_neg", longint'(min_il >= 0), 1);
        check("plant_iL_held_0", iL, 0);
        check_model("plant");

        // PI integrator ramp, saturation at max, and floor at min.
        apply_reset();
        kp = 0; ki = 21; reference = 150 * ONE; max_v = 90 * ONE; min_v = 0;
        tick(0, 1);
        check("integ_step1", duty_q, 3150);
        tick(0, 1);
        tick(0, 1);
        check("integ_step3", duty_q, 9450);
        ki = ONE;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1);
            check($sformatf("integ_sat%0d", i), duty_q, 90 * ONE);
        end
        reference = -50 * ONE;
        tick(0, 1);
        check("integ_down", duty_q, 40 * ONE);
        tick(0, 1);
        check("integ_floor_a", duty_q, 0);
        tick(0, 1);
        check("integ_floor_b", duty_q, 0);

        // Randomised closed loop against the model, with a reference step and a mid-run reset.
        apply_reset();
        kp = ONE / 50; ki = 21; reference = 150 * ONE; max_v = 90 * ONE; min_v = 0; period = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) reference = 300 * ONE;
            if (i == 1000) period = 20 + $urandom_range(0, 60);
            if (i == 3000) begin
                #2 reset = 1'b1;
                #1 check_zero("midrun_reset");
                model_reset();
                @(negedge aclk);
                reset = 1'b0;
            end
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
